ex_mem: RTL

Pipeline register between the execute stage and the memory stage of the 5-stage MIPS core. It captures the execute stage's register-file write request, its HI/LO write request and the multi-cycle multiply-accumulate (madd/maddu/msub/msubu) state. It honours the stall vector from the pipeline controller and a flush request. It returns the captured accumulate count and partial product to the execute stage as `mem_cnt`/`mem_hilo_tempt`, which makes the two-pass accumulate work.

---
 rtl/ex_mem.sv | 111 +++++++++++
 1 files changed

// File: rtl/ex_mem.sv
// ----------------------------------------------------------------------------
// ex_mem : execute -> memory pipeline register of the 5-stage MIPS core.
//
// Captures the execute stage's register-file write request, its HI/LO write
// request and the multi-cycle multiply-accumulate state (pass counter and
// 64-bit partial product). The accumulate state is returned to the execute
// stage as mem_cnt / mem_hilo_tempt so that madd/maddu/msub/msubu can run
// their second pass on the first pass's product.
//
// Ports
//   clk             in   1  clock, rising edge
//   reset           in   1  asynchronous active-high reset, clears everything
//   stall           in   6  controller stall vector {wb,mem,ex,id,if,pc}
//   flush           in   1  clears the stage on the next edge
//   ex_we/waddr/wdata        register-file write request from execute
//   ex_whilo/hi/lo           HI/LO write request from execute
//   ex_cnt          in   5  accumulate pass counter from execute
//   ex_hilo_tempt   in  64  accumulate partial result from execute
//   mem_*                    registered copies of the above
// ----------------------------------------------------------------------------
module ex_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        ex_we,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [4:0]  ex_cnt,
    input  logic [63:0] ex_hilo_tempt,
    output logic        mem_we,
    output logic [4:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic [4:0]  mem_cnt,
    output logic [63:0] mem_hilo_tempt
);

    // Only the execute and memory stall bits matter here.
    logic ex_stall;
    logic mem_stall;
    logic unused_stall;

    assign ex_stall     = stall[3];
    assign mem_stall    = stall[4];
    assign unused_stall = ^{stall[5], stall[2:0]};

    // Payload: the write requests seen by the memory stage.
    // A held memory stage wins over everything except reset and flush; this
    // also covers the illegal "ex running, mem held" encoding, which must not
    // lose the instruction sitting in this register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_waddr <= 5'd0;
            mem_wdata <= 32'd0;
            mem_whilo <= 1'b0;
            mem_hi    <= 32'd0;
            mem_lo    <= 32'd0;
        end else if (flush) begin
            mem_we    <= 1'b0;
            mem_waddr <= 5'd0;
            mem_wdata <= 32'd0;
            mem_whilo <= 1'b0;
            mem_hi    <= 32'd0;
            mem_lo    <= 32'd0;
        end else if (mem_stall) begin
            // hold
        end else if (ex_stall) begin
            // Bubble: memory advances but execute is held, so memory must see
            // no write at all.
            mem_we    <= 1'b0;
            mem_waddr <= 5'd0;
            mem_wdata <= 32'd0;
            mem_whilo <= 1'b0;
            mem_hi    <= 32'd0;
            mem_lo    <= 32'd0;
        end else begin
            mem_we    <= ex_we;
            mem_waddr <= ex_waddr;
            mem_wdata <= ex_wdata;
            mem_whilo <= ex_whilo;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
        end
    end

    // Accumulate state: unlike the payload it keeps loading during a bubble,
    // because the execute stage stalls itself while the first accumulate pass
    // parks its product here for the second pass to pick up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_cnt        <= 5'd0;
            mem_hilo_tempt <= 64'd0;
        end else if (flush) begin
            mem_cnt        <= 5'd0;
            mem_hilo_tempt <= 64'd0;
        end else if (mem_stall) begin
            // hold: an in-flight PASS1 survives until memory releases
        end else begin
            mem_cnt        <= ex_cnt;
            mem_hilo_tempt <= ex_hilo_tempt;
        end
    end

endmodule
